myrisc16_mem_arbiter: RTL

//  Owns the myrisc16 word memory and shares it between two requesters: the
//  CPU core (fetch/load/store) and a host loader/debug port. Single-ported;
//  one access per 3-cycle slot, round-robin on contention.

---
 rtl/myrisc16_mem_arbiter_if.sv | 32 +++
 rtl/myrisc16_mem_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/myrisc16_mem_arbiter_if.sv
// Requester-side bundle for the myrisc16 memory arbiter.
// master = CPU/host requesters, slave = arbiter.
interface myrisc16_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_lock;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        input  cpu_ack, cpu_rdata, host_ack, host_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        output cpu_ack, cpu_rdata, host_ack, host_rdata
    );
endinterface

// File: rtl/myrisc16_mem_arbiter.sv
// myrisc16 word memory shared by CPU and host, round-robin, 3-cycle slots.
// Optional host exclusive lock: define MYRISC16_ARB_LOCK_EN.
module myrisc16_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    myrisc16_mem_arbiter_if.slave bus,
    output logic                  busy,
    output logic [7:0]            out_led
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;
    typedef enum logic {G_CPU, G_HOST} grant_t;

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic host_only;
    logic pick_cpu;
    logic pick_host;

`ifdef MYRISC16_ARB_LOCK_EN
    assign host_only = bus.host_lock && (last_q == G_HOST);
`else
    assign host_only = 1'b0;
    wire unused_lock = bus.host_lock;
`endif

    // CPU wins unless host holds the lock or CPU was served last
    assign pick_cpu  = bus.cpu_req && !host_only &&
                       (!bus.host_req || last_q == G_HOST);
    assign pick_host = bus.host_req && !pick_cpu;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        mem_d        = mem_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_cpu) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    last_d  = G_CPU;
                    state_d = S_ACC;
                end else if (pick_host) begin
                    we_d    = bus.host_we;
                    addr_d  = bus.host_addr;
                    wdata_d = bus.host_wdata;
                    last_d  = G_HOST;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (we_q) begin
                    mem_d[addr_q] = wdata_q;
                end else if (last_q == G_CPU) begin
                    cpu_rdata_d = mem_q[addr_q];
                end else begin
                    host_rdata_d = mem_q[addr_q];
                end
                cpu_ack_d  = (last_q == G_CPU);
                host_ack_d = (last_q == G_HOST);
                state_d    = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= S_IDLE;
            last_q       <= G_HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            busy_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '1;
            end
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.host_rdata = host_rdata_q;
    assign busy           = busy_q;
    assign out_led        = mem_q[DEPTH-1][7:0];
endmodule
